// File: rtl/fork_using_double_buffer_and_fifos.sv
// Broadcast fork: a two-entry input double buffer feeds two independent
// flip-flop FIFOs so consumers a and b each see every accepted word once,
// in order, while draining at their own rates.

module fork_fifo #(
  parameter int width = 8,
  parameter int depth = 10,
  localparam int CW = $clog2(depth + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [width-1:0] push_data,
  input  logic             ready,
  output logic             valid,
  output logic [width-1:0] data,
  output logic [CW-1:0]    count,
  output logic             full
);
  localparam int PW = (depth > 1) ? $clog2(depth) : 1;

  logic [width-1:0] mem [depth];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             pop;
  logic             push_ok;

  // Pointers wrap explicitly so depth need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(depth - 1)) ? '0 : p + PW'(1);
  endfunction

  // Status comes from the registered count only, so a same-cycle pop never
  // frees room for a push into a full FIFO.
  assign full    = (count == CW'(depth));
  assign valid   = (count != '0);
  assign pop     = valid & ready;
  assign push_ok = push & ~full;
  assign data    = mem[rd_ptr];

  // Pointer and occupancy control.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)     rd_ptr <= ptr_inc(rd_ptr);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // Storage array; contents are qualified by count, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end
endmodule

module fork_using_double_buffer_and_fifos #(
  parameter int width = 8,
  parameter int depth = 10,
  localparam int CW = $clog2(depth + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] in_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [width-1:0] a_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [width-1:0] b_data,
  output logic [CW-1:0]    a_count,
  output logic [CW-1:0]    b_count
);
  logic [width-1:0] buf_mem [2];
  logic             wr_slot;
  logic             rd_slot;
  logic [1:0]       buf_count;
  logic [1:0]       buf_count_next;
  logic             in_fire;
  logic             fork_fire;
  logic             a_full;
  logic             b_full;
  logic [width-1:0] buf_head;

  assign in_fire   = in_valid & in_ready;
  // All-or-nothing: the head only leaves the buffer when both FIFOs take it.
  assign fork_fire = (buf_count != 2'd0) & ~a_full & ~b_full;
  assign buf_head  = buf_mem[rd_slot];

  // Next buffer occupancy; simultaneous write and fork leave it unchanged.
  always_comb begin
    buf_count_next = buf_count;
    case ({in_fire, fork_fire})
      2'b10:   buf_count_next = buf_count + 2'd1;
      2'b01:   buf_count_next = buf_count - 2'd1;
      default: ;
    endcase
  end

  // Double-buffer control; in_ready is registered from the next occupancy so
  // upstream never sees a combinational path from the consumers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_slot   <= 1'b0;
      rd_slot   <= 1'b0;
      buf_count <= 2'd0;
      in_ready  <= 1'b1;
    end else begin
      if (in_fire)   wr_slot <= ~wr_slot;
      if (fork_fire) rd_slot <= ~rd_slot;
      buf_count <= buf_count_next;
      in_ready  <= (buf_count_next != 2'd2);
    end
  end

  // Double-buffer data slots.
  always_ff @(posedge clk) begin
    if (in_fire) buf_mem[wr_slot] <= in_data;
  end

  fork_fifo #(.width(width), .depth(depth)) u_fifo_a (
    .clk       (clk),
    .rst       (rst),
    .push      (fork_fire),
    .push_data (buf_head),
    .ready     (a_ready),
    .valid     (a_valid),
    .data      (a_data),
    .count     (a_count),
    .full      (a_full)
  );

  fork_fifo #(.width(width), .depth(depth)) u_fifo_b (
    .clk       (clk),
    .rst       (rst),
    .push      (fork_fire),
    .push_data (buf_head),
    .ready     (b_ready),
    .valid     (b_valid),
    .data      (b_data),
    .count     (b_count),
    .full      (b_full)
  );
endmodule

// File: tb/tb_fork_using_double_buffer_and_fifos.sv
// Directed and random bench for the broadcast fork, with a per-output
// scoreboard fed from accepted input words.

module tb_fork_using_double_buffer_and_fifos;
  localparam int W  = 8;
  localparam int D  = 10;
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          a_valid;
  logic          a_ready = 1'b0;
  logic [W-1:0]  a_data;
  logic          b_valid;
  logic          b_ready = 1'b0;
  logic [W-1:0]  b_data;
  logic [CW-1:0] a_count;
  logic [CW-1:0] b_count;

  int checks = 0;
  int errors = 0;
  int na = 0;
  int nb = 0;
  logic [W-1:0] exp_a [$];
  logic [W-1:0] exp_b [$];

  fork_using_double_buffer_and_fifos #(.width(W), .depth(D)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_data   (a_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_data   (b_data),
    .a_count  (a_count),
    .b_count  (b_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: sampled at the falling edge, ahead of the edge that commits.
  always @(negedge clk) begin
    if (!rst) begin
      exp_a.delete();
      exp_b.delete();
    end else begin
      if (a_valid && a_ready) begin
        na++;
        if (exp_a.size() > 0) chk("a_order", 32'(a_data), 32'(exp_a.pop_front()));
        else                  chk("a_spurious", 32'(exp_a.size()), 32'd1);
      end
      if (b_valid && b_ready) begin
        nb++;
        if (exp_b.size() > 0) chk("b_order", 32'(b_data), 32'(exp_b.pop_front()));
        else                  chk("b_spurious", 32'(exp_b.size()), 32'd1);
      end
      if (in_valid && in_ready) begin
        exp_a.push_back(in_data);
        exp_b.push_back(in_data);
      end
    end
  end

  task automatic send_words(input int base, input int first, input int n, input int max_cyc,
                            output int acc);
    logic took;
    acc = 0;
    for (int c = 0; c < max_cyc && acc < n; c++) begin
      in_valid = 1'b1;
      in_data  = W'(base + first + acc);
      took     = in_ready;
      tick();
      if (took) acc++;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag, input int max_cyc);
    a_ready = 1'b1;
    b_ready = 1'b1;
    for (int c = 0; c < max_cyc && (exp_a.size() > 0 || exp_b.size() > 0); c++) tick();
    chk({tag, "_drain_a"}, 32'(exp_a.size()), 32'd0);
    chk({tag, "_drain_b"}, 32'(exp_b.size()), 32'd0);
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int acc2;
    int na0;
    int nb0;

    // Reset held with in_valid asserted
    #1 rst = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hEE;
    repeat (3) tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_a_valid", 32'(a_valid), 32'd0);
    chk("rst_b_valid", 32'(b_valid), 32'd0);
    chk("rst_a_count", 32'(a_count), 32'd0);
    chk("rst_b_count", 32'(b_count), 32'd0);
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    tick();
    chk("post_rst_a_count", 32'(a_count), 32'd0);
    chk("post_rst_a_valid", 32'(a_valid), 32'd0);

    // Single word latency
    a_ready  = 1'b1;
    b_ready  = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h5A;
    tick();
    in_valid = 1'b0;
    chk("t2_c1_a_valid", 32'(a_valid), 32'd0);
    chk("t2_c1_b_valid", 32'(b_valid), 32'd0);
    tick();
    chk("t2_c2_a_valid", 32'(a_valid), 32'd1);
    chk("t2_c2_a_data", 32'(a_data), 32'h5A);
    chk("t2_c2_b_valid", 32'(b_valid), 32'd1);
    chk("t2_c2_b_data", 32'(b_data), 32'h5A);
    tick();
    chk("t2_c3_a_valid", 32'(a_valid), 32'd0);
    chk("t2_c3_b_valid", 32'(b_valid), 32'd0);

    // Back-to-back stream with both consumers ready
    na0 = na;
    nb0 = nb;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      in_data  = W'(i);
      tick();
      chk("t3_in_ready", 32'(in_ready), 32'd1);
      if (i >= 1) begin
        chk("t3_a_valid", 32'(a_valid), 32'd1);
        chk("t3_a_data", 32'(a_data), 32'(i - 1));
        chk("t3_b_data", 32'(b_data), 32'(i - 1));
      end
    end
    in_valid = 1'b0;
    drain("t3", 20);
    chk("t3_na", 32'(na - na0), 32'd100);
    chk("t3_nb", 32'(nb - nb0), 32'd100);

    // Skewed drain: b stalled
    na0 = na;
    nb0 = nb;
    a_ready = 1'b1;
    b_ready = 1'b0;
    send_words(0, 0, 20, 30, acc);
    chk("t4_accepted", 32'(acc), 32'd12);
    chk("t4_in_ready", 32'(in_ready), 32'd0);
    chk("t4_b_count", 32'(b_count), 32'd10);
    chk("t4_a_count", 32'(a_count), 32'd0);
    chk("t4_na", 32'(na - na0), 32'd10);
    b_ready = 1'b1;
    send_words(0, 12, 8, 100, acc2);
    chk("t4_accepted2", 32'(acc2), 32'd8);
    drain("t4", 60);
    chk("t4_na_total", 32'(na - na0), 32'd20);
    chk("t4_nb_total", 32'(nb - nb0), 32'd20);

    // Full edge on FIFO a with pointer wrap
    pulse_reset();
    a_ready = 1'b0;
    b_ready = 1'b1;
    send_words(8'h50, 0, 11, 40, acc);
    chk("t5_accepted", 32'(acc), 32'd11);
    repeat (3) tick();
    chk("t5_a_count_full", 32'(a_count), 32'd10);
    chk("t5_a_head", 32'(a_data), 32'h50);
    chk("t5_b_valid_held", 32'(b_valid), 32'd0);
    a_ready = 1'b1;
    tick();
    chk("t5_a_count_edge", 32'(a_count), 32'd9);
    chk("t5_a_head2", 32'(a_data), 32'h51);
    chk("t5_b_valid_edge", 32'(b_valid), 32'd0);
    a_ready = 1'b0;
    tick();
    chk("t5_a_count_push", 32'(a_count), 32'd10);
    chk("t5_b_valid_push", 32'(b_valid), 32'd1);
    chk("t5_b_data_push", 32'(b_data), 32'h5A);
    a_ready = 1'b1;
    for (int j = 0; j < 10; j++) begin
      chk("t5_wrap_data", 32'(a_data), 32'(8'h51 + j));
      tick();
    end
    chk("t5_a_empty", 32'(a_valid), 32'd0);
    drain("t5", 20);

    // Random traffic with asynchronous reset mid-run
    for (int cyc = 0; cyc < 10000; cyc++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = W'($urandom);
      a_ready  = 1'($urandom_range(0, 1));
      b_ready  = 1'($urandom_range(0, 1));
      if (cyc == 5000) begin
        #2 rst = 1'b0;
        #1;
        chk("t6_rst_a_valid", 32'(a_valid), 32'd0);
        chk("t6_rst_b_valid", 32'(b_valid), 32'd0);
        chk("t6_rst_in_ready", 32'(in_ready), 32'd1);
        chk("t6_rst_a_count", 32'(a_count), 32'd0);
        chk("t6_rst_b_count", 32'(b_count), 32'd0);
        tick();
        rst = 1'b1;
      end else begin
        tick();
        chk("t6_a_count_max", {31'd0, a_count <= CW'(D)}, 32'd1);
        chk("t6_b_count_max", {31'd0, b_count <= CW'(D)}, 32'd1);
      end
    end
    in_valid = 1'b0;
    drain("t6", 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
